// File: rtl/kernel_top_vn_stream_join2_pkg.sv
// Shared constants and types for the two-lane stream join and its lane FIFOs.
package kernel_top_vn_stream_join2_pkg;

  localparam int STREAMW_DEF = 34;
  localparam int DEPTH_DEF   = 4;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [STREAMW_DEF-1:0] lane_word_t;

endpackage

// File: rtl/kernel_top_vn_stream_join2_lane_fifo.sv
// Circular elastic FIFO for one join lane; the full flag is a register so
// upstream ready never depends combinationally on the downstream pop.
module kernel_top_vn_lane_fifo
  import kernel_top_vn_stream_join2_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNTW    = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [STREAMW-1:0] din,
  output logic [STREAMW-1:0] head,
  output logic [CNTW-1:0]    count,
  output logic               full,
  output logic               empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [STREAMW-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CNTW-1:0]    count_q;
  logic [CNTW-1:0]    count_nxt;
  logic               full_q;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // full_q resets high so no push is accepted while reset is held; it tracks
  // count_nxt so a push is still refused in a full cycle that also pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNTW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/kernel_top_vn_stream_join2.sv
// Two-lane stream join: each lane is buffered in its own FIFO and one joined
// word (out1, out2) is emitted only when both lanes hold data.
module kernel_top_vn_stream_join2
  import kernel_top_vn_stream_join2_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNTW    = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  output logic               iready_in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in2,
  output logic               iready_in2,
  output logic               ovalid,
  input  logic               oready,
  output logic [STREAMW-1:0] out1,
  output logic [STREAMW-1:0] out2,
  output logic [CNTW-1:0]    count1,
  output logic [CNTW-1:0]    count2
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and once raised, valid and data hold until taken.
  logic full1, full2;
  logic empty1, empty2;
  logic push1, push2;
  logic pop;

  assign iready_in1 = ~full1;
  assign iready_in2 = ~full2;
  assign push1      = ivalid_in1 & ~full1;
  assign push2      = ivalid_in2 & ~full2;
  assign ovalid     = ~empty1 & ~empty2;
  assign pop        = ovalid & oready;

  kernel_top_vn_lane_fifo #(
    .STREAMW (STREAMW),
    .DEPTH   (DEPTH),
    .CNTW    (CNTW)
  ) u_lane1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop),
    .din   (in1),
    .head  (out1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  kernel_top_vn_lane_fifo #(
    .STREAMW (STREAMW),
    .DEPTH   (DEPTH),
    .CNTW    (CNTW)
  ) u_lane2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .pop   (pop),
    .din   (in2),
    .head  (out2),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

endmodule

// File: doc/kernel_top_vn_stream_join2.md
# kernel_top_vn_stream_join2

Receive-side counterpart of the local delay buffers. It accepts two independently handshaked lanes, such as the tap outputs of delay buffers on mismatched-latency parallel paths. It holds each lane in a small elastic FIFO and emits one joined transfer only when both lanes hold data. It sits at the merge point of two parallel kernel paths and absorbs residual skew. It also converts the buffers' valid-only behaviour into true backpressure toward upstream.

## Interface
Parameters:
- STREAMW, 34, lane data width in bits.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- CNTW, $clog2(DEPTH)+1, occupancy counter width (derived; not for override).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- ivalid_in1  input  1  lane 1 data valid.
- in1  input  STREAMW  lane 1 data.
- iready_in1  output  1  lane 1 FIFO not full.
- ivalid_in2  input  1  lane 2 data valid.
- in2  input  STREAMW  lane 2 data.
- iready_in2  output  1  lane 2 FIFO not full.
- ovalid  output  1  both lanes non-empty.
- oready  input  1  downstream accepts joined word.
- out1  output  STREAMW  lane 1 head entry.
- out2  output  STREAMW  lane 2 head entry.
- count1  output  CNTW  lane 1 occupancy.
- count2  output  CNTW  lane 2 occupancy.

## Operation
- Each lane is a circular FIFO: storage of DEPTH x STREAMW, write pointer, read pointer, occupancy counter.
- Push on lane k: ivalid_ink & iready_ink. Writes ink at the write pointer, advances the pointer modulo DEPTH, and increments countk.
- iready_ink = (countk != DEPTH), from registered state only. There is no combinational path from oready to iready.
- ovalid = (count1 != 0) & (count2 != 0).
- Pop: ovalid & oready. Both lanes advance their read pointers and decrement their counts in the same cycle. A lane never pops alone.
- Push and pop on the same lane in the same cycle: the count is unchanged and both pointers advance.
- At full, push is blocked even if pop occurs that cycle. This is deliberate and trades one bubble for a registered iready.
- At empty there is no bypass. Data written this cycle is visible next cycle.
- out1/out2 are combinational reads of the head entries. They are undefined while ovalid=0, and benches must not check them then.
- Word order within each lane is preserved. The joined output pairs the n-th accepted word of lane 1 with the n-th accepted word of lane 2.
- Pointers wrap from DEPTH-1 to 0.
- Counters never exceed DEPTH and never underflow. This is guaranteed by the push/pop qualifications above.

## Timing
- Reset (rst=0), applied asynchronously:
  - pointers = 0, count1 = count2 = 0.
  - ovalid = 0.
  - iready_in1 = iready_in2 = 0.
  - Storage is not reset.
- First cycle after reset release: iready_in1 = iready_in2 = 1.
- Reset mid-operation: all buffered words are discarded, and ovalid drops in the same cycle reset asserts.
- Latency: a word pushed at edge t is at the head at t+1. ovalid rises at t+1 if the other lane is already non-empty.
- Throughput: one joined word per cycle when both lanes are streaming and oready=1.
- Skew tolerance: lanes may run up to DEPTH words apart before the leading lane stalls via iready.
- Once asserted, ovalid stays high with stable out1/out2 until the pop. An AXI4-stream rule.

## Structure
- Shared package holds:
  - the default STREAMW and DEPTH constants;
  - the count-width helper (clog2(DEPTH)+1);
  - the lane-word typedef logic [STREAMW-1:0].
- One natural sub-module, kernel_top_vn_lane_fifo: ports push, pop, data in, head out, count, full, empty. It is instantiated twice.
- The top level holds only the join logic: the ovalid AND, and the shared pop fanned out to both FIFOs.

## Test plan
- Reset then idle: rst low for 3 cycles, then high. During reset: ovalid=0 and iready_in1=iready_in2=0. First post-reset cycle: both iready=1, counts=0.
- Aligned streaming: both lanes push 0x1..0x8 every cycle with oready=1. Joined pairs (1,1)..(8,8) appear, the first one cycle after the first push. ovalid stays high for 8 consecutive cycles.
- Skew: lane 1 pushes 0xA0..0xA3 while lane 2 is idle. count1=4, iready_in1=0, ovalid=0. Lane 2 then pushes 0xB0. Next cycle: ovalid=1 with out1=0xA0, out2=0xB0.
- Backpressure: oready=0 with both lanes fed for 6 cycles. Both counts saturate at 4 and both iready=0. Head stays 1st word. Raising oready drains in order with no loss or duplication.
- Wrap-around: push and pop 3*DEPTH words with random ivalid and oready gaps. The scoreboard matches the order, and pointers wrap cleanly.
- Reset mid-stream: assert rst with count1=3, count2=2. ovalid and iready drop immediately. After release, counts are 0 and no stale pair is emitted.
